a2d_chnl_sched: RTL and testbench

//  Round-robin scheduler that shares the single A2D SPI monarch among the four analog sources
//  (left load cell, right load cell, steer pot, battery) of the ADC128S.

---
 rtl/segway_a2d_pkg.sv | 26 ++
 rtl/a2d_chnl_sched_if.sv | 25 ++
 rtl/a2d_chnl_sched.sv | 138 +++++++++++++
 tb/tb_a2d_chnl_sched.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/segway_a2d_pkg.sv
// Shared types and constants for the Segway A2D channel scheduler.
// Holds the scheduler state encoding, the channel-index type, the default
// ADC128S channel numbers and the helper that builds an ADC128S command word.
package segway_a2d_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    XMIT1 = 2'd1,
    GAP   = 2'd2,
    XMIT2 = 2'd3
  } a2d_state_t;

  typedef logic [1:0] chnl_idx_t;

  localparam logic [2:0] CH_LFT_DEF   = 3'd0;
  localparam logic [2:0] CH_RGHT_DEF  = 3'd4;
  localparam logic [2:0] CH_STEER_DEF = 3'd5;
  localparam logic [2:0] CH_BATT_DEF  = 3'd6;
  localparam int         TMO_CYC_DEF  = 2048;

  // ADC128S control word: channel address sits in bits [13:11], rest zero.
  function automatic logic [15:0] a2d_cmd(input logic [2:0] chnl);
    return {2'b00, chnl, 11'h000};
  endfunction

endpackage

// File: rtl/a2d_chnl_sched_if.sv
// Handshake between the channel scheduler and the SPI monarch.
// The scheduler is the master: it launches transactions with spi_wrt/spi_cmd
// and receives spi_done/spi_rd back from the monarch.
interface a2d_chnl_sched_if;

  logic        spi_wrt;
  logic [15:0] spi_cmd;
  logic        spi_done;
  logic [15:0] spi_rd;

  modport master (
    output spi_wrt,
    output spi_cmd,
    input  spi_done,
    input  spi_rd
  );

  modport slave (
    input  spi_wrt,
    input  spi_cmd,
    output spi_done,
    output spi_rd
  );

endinterface

// File: rtl/a2d_chnl_sched.sv
// Round-robin A2D scheduler for the Segway.
// Each nxt request runs one two-transaction ADC128S read on the next channel
// (LFT -> RGHT -> STEER -> BATT -> LFT). The first transaction only addresses
// the channel; the second returns its conversion, which lands in that
// channel's holding register. A request arriving while busy is remembered in
// a one-deep pending flag. A transaction that never completes is abandoned
// after TMO_CYC clocks without advancing the channel, so the next request
// retries it.
module a2d_chnl_sched
  import segway_a2d_pkg::*;
#(
  parameter logic [2:0] CH_LFT   = CH_LFT_DEF,
  parameter logic [2:0] CH_RGHT  = CH_RGHT_DEF,
  parameter logic [2:0] CH_STEER = CH_STEER_DEF,
  parameter logic [2:0] CH_BATT  = CH_BATT_DEF,
  parameter int         TMO_CYC  = TMO_CYC_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     nxt,
  a2d_chnl_sched_if.master         spi,
  output logic [11:0]              lft_ld,
  output logic [11:0]              rght_ld,
  output logic [11:0]              steer_pot,
  output logic [11:0]              batt,
  output logic                     cnv_done,
  output logic                     all_vld,
  output logic                     tmo_err
);

  // Timer only has to reach TMO_CYC-2; abort happens on the edge that would
  // take it to TMO_CYC-1, so tmo_err shows TMO_CYC-1 clocks after spi_wrt.
  localparam int             TW       = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;
  localparam logic [TW-1:0]  TMO_LAST = TW'(TMO_CYC - 2);

  a2d_state_t    state;
  chnl_idx_t     idx;
  logic          pend;
  logic [TW-1:0] timer;
  logic [3:0]    seen;
  logic [2:0]    cur_chnl;
  logic [3:0]    idx_hot;
  logic          tmo_hit;

  // Map the round-robin index onto the physical ADC128S channel and its
  // bit in the converted-at-least-once mask.
  always_comb begin
    cur_chnl = CH_LFT;
    case (idx)
      2'd0:    cur_chnl = CH_LFT;
      2'd1:    cur_chnl = CH_RGHT;
      2'd2:    cur_chnl = CH_STEER;
      default: cur_chnl = CH_BATT;
    endcase
    idx_hot = 4'b0001 << idx;
    tmo_hit = (timer == TMO_LAST);
  end

  // Scheduler FSM with all outputs registered; completion beats timeout.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= 2'd0;
      pend        <= 1'b0;
      timer       <= '0;
      seen        <= 4'b0000;
      spi.spi_wrt <= 1'b0;
      spi.spi_cmd <= 16'h0000;
      lft_ld      <= 12'h000;
      rght_ld     <= 12'h000;
      steer_pot   <= 12'h000;
      batt        <= 12'h000;
      cnv_done    <= 1'b0;
      all_vld     <= 1'b0;
      tmo_err     <= 1'b0;
    end else begin
      spi.spi_wrt <= 1'b0;
      cnv_done    <= 1'b0;
      tmo_err     <= 1'b0;

      if (nxt && (state != IDLE))
        pend <= 1'b1;

      case (state)
        IDLE: begin
          if (nxt || pend) begin
            state       <= XMIT1;
            spi.spi_wrt <= 1'b1;
            spi.spi_cmd <= a2d_cmd(cur_chnl);
            pend        <= 1'b0;
            timer       <= '0;
          end
        end

        XMIT1: begin
          if (spi.spi_done) begin
            state <= GAP;
          end else if (tmo_hit) begin
            tmo_err <= 1'b1;
            state   <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        GAP: begin
          spi.spi_wrt <= 1'b1;
          timer       <= '0;
          state       <= XMIT2;
        end

        XMIT2: begin
          if (spi.spi_done) begin
            case (idx)
              2'd0:    lft_ld    <= spi.spi_rd[11:0];
              2'd1:    rght_ld   <= spi.spi_rd[11:0];
              2'd2:    steer_pot <= spi.spi_rd[11:0];
              default: batt      <= spi.spi_rd[11:0];
            endcase
            cnv_done <= 1'b1;
            seen     <= seen | idx_hot;
            all_vld  <= &(seen | idx_hot);
            idx      <= chnl_idx_t'(idx + 2'd1);
            state    <= IDLE;
          end else if (tmo_hit) begin
            tmo_err <= 1'b1;
            state   <= IDLE;
          end else begin
            timer <= timer + TW'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_a2d_chnl_sched.sv
// Directed bench for a2d_chnl_sched. A small behavioural SPI responder
// answers every spi_wrt SPI_LAT negedges later with {4'hA, value of the
// addressed channel}; with that fixed latency every round is deterministic:
// spi_wrt at n0, 2nd spi_wrt at n12, cnv_done at n23 (nX = X-th negedge).
module tb_a2d_chnl_sched;

  localparam int TMO     = 64;
  localparam int SPI_LAT = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        nxt;
  logic [11:0] lft_ld;
  logic [11:0] rght_ld;
  logic [11:0] steer_pot;
  logic [11:0] batt;
  logic        cnv_done;
  logic        all_vld;
  logic        tmo_err;

  a2d_chnl_sched_if bus();

  a2d_chnl_sched #(.TMO_CYC(TMO)) dut (
    .clk       (clk),
    .rst       (rst),
    .nxt       (nxt),
    .spi       (bus),
    .lft_ld    (lft_ld),
    .rght_ld   (rght_ld),
    .steer_pot (steer_pot),
    .batt      (batt),
    .cnv_done  (cnv_done),
    .all_vld   (all_vld),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  int          cnv_seen = 0;
  bit          spi_en = 1'b1;
  logic [11:0] ch_val [8];
  logic [2:0]  rsp_ch;

  // Count result pulses for the scenarios that check how many rounds ran.
  always @(negedge clk) if (cnv_done === 1'b1) cnv_seen++;

  // SPI monarch + ADC stand-in.
  initial begin
    bus.spi_done = 1'b0;
    bus.spi_rd   = 16'h0000;
    forever begin
      @(negedge clk);
      if (bus.spi_wrt === 1'b1 && spi_en) begin
        rsp_ch = bus.spi_cmd[13:11];
        repeat (SPI_LAT) @(negedge clk);
        bus.spi_rd   = {4'hA, ch_val[rsp_ch]};
        bus.spi_done = 1'b1;
        @(negedge clk);
        bus.spi_done = 1'b0;
        bus.spi_rd   = 16'hFFFF;
      end
    end
  end

  task automatic pulse_nxt();
    @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    nxt = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.spi_wrt !== 1'b0) begin bad++; $display("[TB] FAIL rst_wrt got=%0b exp=0", bus.spi_wrt); end
    total++; if (bus.spi_cmd !== 16'h0000) begin bad++; $display("[TB] FAIL rst_cmd got=%h exp=0000", bus.spi_cmd); end
    total++; if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0) begin bad++; $display("[TB] FAIL rst_regs got=%h exp=0", {lft_ld, rght_ld, steer_pot, batt}); end
    total++; if ({cnv_done, all_vld, tmo_err} !== 3'b000) begin bad++; $display("[TB] FAIL rst_flags got=%b exp=000", {cnv_done, all_vld, tmo_err}); end
    rst = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_sequence();
    logic [15:0] exp_cmd [4];
    logic [11:0] exp_val [4];
    logic [11:0] got;
    int          gap_k;
    exp_cmd = '{16'h0000, 16'h2000, 16'h2800, 16'h3000};
    exp_val = '{12'd330, 12'd330, 12'h800, 12'hC00};
    for (int i = 0; i < 4; i++) begin
      pulse_nxt();
      total++; if (bus.spi_wrt !== 1'b1) begin bad++; $display("[TB] FAIL seq_wrt%0d got=%0b exp=1", i, bus.spi_wrt); end
      total++; if (bus.spi_cmd !== exp_cmd[i]) begin bad++; $display("[TB] FAIL seq_cmd%0d got=%h exp=%h", i, bus.spi_cmd, exp_cmd[i]); end
      if (i == 0) begin
        gap_k = 0;
        for (int k = 1; k <= 30; k++) begin
          @(negedge clk);
          if (bus.spi_wrt === 1'b1) begin gap_k = k; break; end
        end
        total++; if (gap_k != 12) begin bad++; $display("[TB] FAIL seq_gap got=%0d exp=12", gap_k); end
        repeat (23 - gap_k) @(negedge clk);
      end else begin
        repeat (23) @(negedge clk);
      end
      case (i)
        0:       got = lft_ld;
        1:       got = rght_ld;
        2:       got = steer_pot;
        default: got = batt;
      endcase
      total++; if (cnv_done !== 1'b1) begin bad++; $display("[TB] FAIL seq_cnv%0d got=%0b exp=1", i, cnv_done); end
      total++; if (got !== exp_val[i]) begin bad++; $display("[TB] FAIL seq_val%0d got=%h exp=%h", i, got, exp_val[i]); end
      total++; if (all_vld !== (i == 3)) begin bad++; $display("[TB] FAIL seq_allvld%0d got=%0b exp=%0b", i, all_vld, (i == 3)); end
      if (i == 0) begin
        @(negedge clk);
        total++; if (cnv_done !== 1'b0) begin bad++; $display("[TB] FAIL seq_cnv_pulse got=%0b exp=0", cnv_done); end
        total++; if (rght_ld !== 12'h000) begin bad++; $display("[TB] FAIL seq_rght_early got=%h exp=000", rght_ld); end
      end
      repeat (100) @(negedge clk);
    end
  endtask

  task automatic test_pending();
    int c0;
    c0 = cnv_seen;
    pulse_nxt();
    repeat (10) @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    repeat (4) @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    repeat (7) @(negedge clk);
    total++; if (cnv_done !== 1'b1) begin bad++; $display("[TB] FAIL pend_cnv1 got=%0b exp=1", cnv_done); end
    @(negedge clk);
    total++; if (bus.spi_wrt !== 1'b1) begin bad++; $display("[TB] FAIL pend_wrt got=%0b exp=1", bus.spi_wrt); end
    total++; if (bus.spi_cmd !== 16'h2000) begin bad++; $display("[TB] FAIL pend_cmd got=%h exp=2000", bus.spi_cmd); end
    repeat (100) @(negedge clk);
    total++; if (cnv_seen - c0 != 2) begin bad++; $display("[TB] FAIL pend_rounds got=%0d exp=2", cnv_seen - c0); end
  endtask

  task automatic test_back_to_back();
    pulse_nxt();
    total++; if (bus.spi_cmd !== 16'h2800) begin bad++; $display("[TB] FAIL b2b_cmd1 got=%h exp=2800", bus.spi_cmd); end
    repeat (22) @(negedge clk);
    nxt = 1'b1;
    @(negedge clk);
    nxt = 1'b0;
    total++; if (cnv_done !== 1'b1 || steer_pot !== 12'h800) begin bad++; $display("[TB] FAIL b2b_first got=%0b/%h exp=1/800", cnv_done, steer_pot); end
    @(negedge clk);
    total++; if (bus.spi_wrt !== 1'b1 || bus.spi_cmd !== 16'h3000) begin bad++; $display("[TB] FAIL b2b_restart got=%0b/%h exp=1/3000", bus.spi_wrt, bus.spi_cmd); end
    repeat (23) @(negedge clk);
    total++; if (cnv_done !== 1'b1 || batt !== 12'hC00) begin bad++; $display("[TB] FAIL b2b_second got=%0b/%h exp=1/C00", cnv_done, batt); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_wrap();
    logic [15:0] exp_cmd [5];
    exp_cmd = '{16'h0000, 16'h2000, 16'h2800, 16'h3000, 16'h0000};
    ch_val[0] = 12'h3FF;
    for (int i = 0; i < 5; i++) begin
      pulse_nxt();
      total++; if (bus.spi_cmd !== exp_cmd[i]) begin bad++; $display("[TB] FAIL wrap_cmd%0d got=%h exp=%h", i, bus.spi_cmd, exp_cmd[i]); end
      repeat (23) @(negedge clk);
      total++; if (cnv_done !== 1'b1) begin bad++; $display("[TB] FAIL wrap_cnv%0d got=%0b exp=1", i, cnv_done); end
      repeat (20) @(negedge clk);
    end
    total++; if (lft_ld !== 12'h3FF) begin bad++; $display("[TB] FAIL wrap_lft got=%h exp=3FF", lft_ld); end
  endtask

  task automatic test_timeout();
    int c0;
    int tk;
    spi_en = 1'b0;
    c0 = cnv_seen;
    pulse_nxt();
    total++; if (bus.spi_cmd !== 16'h2000) begin bad++; $display("[TB] FAIL tmo_cmd got=%h exp=2000", bus.spi_cmd); end
    tk = -1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (tmo_err === 1'b1) begin tk = k; break; end
    end
    total++; if (tk != TMO - 1) begin bad++; $display("[TB] FAIL tmo_delay got=%0d exp=%0d", tk, TMO - 1); end
    @(negedge clk);
    total++; if (tmo_err !== 1'b0) begin bad++; $display("[TB] FAIL tmo_pulse got=%0b exp=0", tmo_err); end
    repeat (20) @(negedge clk);
    total++; if (rght_ld !== 12'd330 || cnv_seen != c0) begin bad++; $display("[TB] FAIL tmo_keep got=%h/%0d exp=14A/%0d", rght_ld, cnv_seen, c0); end
    spi_en = 1'b1;
    ch_val[4] = 12'h123;
    pulse_nxt();
    total++; if (bus.spi_cmd !== 16'h2000) begin bad++; $display("[TB] FAIL tmo_retry_cmd got=%h exp=2000", bus.spi_cmd); end
    repeat (23) @(negedge clk);
    total++; if (cnv_done !== 1'b1 || rght_ld !== 12'h123) begin bad++; $display("[TB] FAIL tmo_retry_val got=%0b/%h exp=1/123", cnv_done, rght_ld); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_rst_gap();
    ch_val[5] = 12'h555;
    pulse_nxt();
    total++; if (bus.spi_cmd !== 16'h2800) begin bad++; $display("[TB] FAIL rgap_cmd got=%h exp=2800", bus.spi_cmd); end
    repeat (11) @(negedge clk);
    total++; if (bus.spi_wrt !== 1'b0) begin bad++; $display("[TB] FAIL rgap_idle got=%0b exp=0", bus.spi_wrt); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (bus.spi_wrt !== 1'b0 || bus.spi_cmd !== 16'h0000) begin bad++; $display("[TB] FAIL rgap_bus got=%0b/%h exp=0/0000", bus.spi_wrt, bus.spi_cmd); end
    total++; if ({lft_ld, rght_ld, steer_pot, batt} !== 48'h0) begin bad++; $display("[TB] FAIL rgap_regs got=%h exp=0", {lft_ld, rght_ld, steer_pot, batt}); end
    total++; if ({cnv_done, all_vld, tmo_err} !== 3'b000) begin bad++; $display("[TB] FAIL rgap_flags got=%b exp=000", {cnv_done, all_vld, tmo_err}); end
    repeat (40) @(negedge clk);
    pulse_nxt();
    total++; if (bus.spi_cmd !== 16'h0000) begin bad++; $display("[TB] FAIL rgap_lft_cmd got=%h exp=0000", bus.spi_cmd); end
    repeat (23) @(negedge clk);
    total++; if (cnv_done !== 1'b1 || lft_ld !== 12'h3FF || steer_pot !== 12'h000) begin bad++; $display("[TB] FAIL rgap_lft got=%0b/%h/%h exp=1/3FF/000", cnv_done, lft_ld, steer_pot); end
    total++; if (all_vld !== 1'b0) begin bad++; $display("[TB] FAIL rgap_allvld got=%0b exp=0", all_vld); end
  endtask

  // Scenarios run in order; each relies on the channel index left by the last.
  initial begin
    rst = 1'b1;
    nxt = 1'b0;
    for (int i = 0; i < 8; i++) ch_val[i] = 12'h0F0 + 12'(i);
    ch_val[0] = 12'd330;
    ch_val[4] = 12'd330;
    ch_val[5] = 12'h800;
    ch_val[6] = 12'hC00;
    test_reset();
    test_sequence();
    test_pending();
    test_back_to_back();
    test_wrap();
    test_timeout();
    test_rst_gap();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
